// File: rtl/acq_pkg.sv
// Shared types and parameter helpers for the pre/post-trigger capture buffer.
package acq_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FILL  = 3'd1,
    ARMED = 3'd2,
    POST  = 3'd3,
    DONE  = 3'd4
  } acq_state_e;

  // Total ring size in samples.
  function automatic int depth_f(input int addr_w);
    return 1 << addr_w;
  endfunction

  // Samples captured from the trigger sample onwards (trigger included).
  function automatic int post_depth_f(input int addr_w, input int pre_depth);
    return (1 << addr_w) - pre_depth;
  endfunction

  // Pretrigger depth must leave room for at least the trigger sample.
  function automatic bit pre_depth_ok(input int addr_w, input int pre_depth);
    return (pre_depth >= 1) && (pre_depth <= (1 << addr_w) - 1);
  endfunction

endpackage

// File: rtl/acq_trig_buffer_if.sv
// Capture-side and readout-side signals of the trigger buffer.
interface acq_trig_buffer_if #(
  parameter int DATA_W = 10,
  parameter int ADDR_W = 11
);
  logic [DATA_W-1:0] din;
  logic              din_valid;
  logic              arm;
  logic              trig;
  logic              cont;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_idx;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic              wrap;
  logic              busy;
  logic              done;
  logic [ADDR_W-1:0] trig_ptr;
  logic [ADDR_W-1:0] start_ptr;

  modport master (
    output din, din_valid, arm, trig, cont, rd_en, rd_idx,
    input  rd_data, rd_valid, wrap, busy, done, trig_ptr, start_ptr
  );

  modport slave (
    input  din, din_valid, arm, trig, cont, rd_en, rd_idx,
    output rd_data, rd_valid, wrap, busy, done, trig_ptr, start_ptr
  );
endinterface

// File: rtl/acq_dpram.sv
// Simple dual-port RAM: one write port, one registered read-first read port.
module acq_dpram #(
  parameter int DATA_W = 10,
  parameter int ADDR_W = 11
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**ADDR_W];
  logic [DATA_W-1:0] rdata_d, rdata_q;

  // Array write; contents are intentionally never cleared.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Read samples the array before this edge's write lands (read-first); hold otherwise.
  always_comb begin
    rdata_d = rdata_q;
    if (re) rdata_d = mem[raddr];
  end

  // Output register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rdata_q <= '0;
    else        rdata_q <= rdata_d;
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/acq_trig_buffer.sv
// Pre/post-trigger capture ring with trigger FSM and trigger-relative readout.
module acq_trig_buffer
  import acq_pkg::*;
#(
  parameter int DATA_W    = 10,
  parameter int ADDR_W    = 11,
  parameter int PRE_DEPTH = 512
) (
  input logic              clk,
  input logic              rst_n,
  acq_trig_buffer_if.slave bus
);

  localparam int POST_DEPTH = post_depth_f(ADDR_W, PRE_DEPTH);
  localparam logic [ADDR_W-1:0] PRE_PTR   = ADDR_W'(PRE_DEPTH);
  localparam logic [ADDR_W-1:0] FILL_LAST = ADDR_W'(PRE_DEPTH - 1);
  localparam logic [ADDR_W:0]   POST_LAST = (ADDR_W+1)'(POST_DEPTH - 1);

  if (!pre_depth_ok(ADDR_W, PRE_DEPTH)) begin : g_bad_pre
    $error("acq_trig_buffer: PRE_DEPTH out of range 1..DEPTH-1");
  end

  acq_state_e        state_d, state_q;
  logic [ADDR_W-1:0] wr_ptr_d, wr_ptr_q;
  logic [ADDR_W-1:0] fill_cnt_d, fill_cnt_q;
  logic [ADDR_W:0]   post_cnt_d, post_cnt_q;
  logic [ADDR_W-1:0] trig_ptr_d, trig_ptr_q;
  logic              trig_vld_d, trig_vld_q;
  logic              wrap_d, wrap_q;
  logic              rd_valid_d, rd_valid_q;
  logic              we;
  logic [ADDR_W-1:0] start_ptr;
  logic [ADDR_W-1:0] rd_addr;

  // Capture FSM: arm restarts from any state and wins over trig; arm cycle itself does not write.
  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    fill_cnt_d = fill_cnt_q;
    post_cnt_d = post_cnt_q;
    trig_ptr_d = trig_ptr_q;
    trig_vld_d = trig_vld_q;
    we         = 1'b0;
    if (bus.arm) begin
      state_d    = FILL;
      wr_ptr_d   = '0;
      fill_cnt_d = '0;
      post_cnt_d = '0;
    end else begin
      case (state_q)
        IDLE: we = bus.din_valid && bus.cont;
        FILL: begin
          we = bus.din_valid;
          if (we) begin
            fill_cnt_d = fill_cnt_q + 1'b1;
            if (fill_cnt_q == FILL_LAST) state_d = ARMED;
          end
        end
        ARMED: begin
          we = bus.din_valid;
          if (we && bus.trig) begin
            trig_ptr_d = wr_ptr_q;
            trig_vld_d = 1'b1;
            post_cnt_d = (ADDR_W+1)'(1);
            // A one-sample post window completes on the trigger sample itself.
            state_d    = (POST_DEPTH == 1) ? DONE : POST;
          end
        end
        POST: begin
          we = bus.din_valid;
          if (we) begin
            post_cnt_d = post_cnt_q + 1'b1;
            if (post_cnt_q == POST_LAST) state_d = DONE;
          end
        end
        DONE:    we = 1'b0;
        default: state_d = IDLE;
      endcase
    end
    if (we) wr_ptr_d = wr_ptr_q + 1'b1;
    wrap_d     = we && (wr_ptr_q == '1);
    rd_valid_d = bus.rd_en;
  end

  // State and pointer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      fill_cnt_q <= '0;
      post_cnt_q <= '0;
      trig_ptr_q <= '0;
      trig_vld_q <= 1'b0;
      wrap_q     <= 1'b0;
      rd_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      fill_cnt_q <= fill_cnt_d;
      post_cnt_q <= post_cnt_d;
      trig_ptr_q <= trig_ptr_d;
      trig_vld_q <= trig_vld_d;
      wrap_q     <= wrap_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  // Oldest sample of the window; held at 0 until a trigger has been seen since reset.
  assign start_ptr = trig_vld_q ? (trig_ptr_q - PRE_PTR) : '0;
  assign rd_addr   = start_ptr + bus.rd_idx;

  acq_dpram #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_ram (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (we),
    .waddr (wr_ptr_q),
    .wdata (bus.din),
    .re    (bus.rd_en),
    .raddr (rd_addr),
    .rdata (bus.rd_data)
  );

  assign bus.rd_valid  = rd_valid_q;
  assign bus.wrap      = wrap_q;
  assign bus.busy      = (state_q == FILL) || (state_q == ARMED) || (state_q == POST);
  assign bus.done      = (state_q == DONE);
  assign bus.trig_ptr  = trig_ptr_q;
  assign bus.start_ptr = start_ptr;

endmodule
